// File: rtl/line_window_3x3_gen.sv
// line_window_3x3_gen
//   Assembles a registered 3x3 pixel window from the current-line pixel and
//   the two line-buffer taps. Frame syncs are delayed to match the window.
//   A flag marks windows that lie fully inside the image.
//
// Ports
//   clk, rst_n                   pixel clock, asynchronous active-low reset
//   per_frame_vsync/href/clken   input frame sync, line valid, pixel strobe
//   per_img_y                    current-line pixel
//   tap_row1, tap_row2           previous and line-before-previous pixels,
//                                valid one cycle after the pixel's clken
//   post_frame_vsync/href/clken  input syncs delayed by 2 cycles
//   matrix_p11..p33              window; row 1 is oldest, column 3 is newest
//   post_window_valid            window centred at (row-1, col-1) is interior
module line_window_3x3_gen #(
  parameter int MAX_COLS = 1024,
  parameter int MAX_ROWS = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_y,
  input  logic [7:0] tap_row1,
  input  logic [7:0] tap_row2,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33,
  output logic       post_window_valid
);
  localparam int COL_W = $clog2(MAX_COLS) + 1;
  localparam int ROW_W = $clog2(MAX_ROWS) + 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_COLS);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAX_ROWS);

  logic [7:0]       y_p1_q, y_p1_d;
  logic             vsync_p1_q, vsync_p1_d, href_p1_q, href_p1_d;
  logic             clken_p1_q, clken_p1_d;
  logic             vsync_p2_q, vsync_p2_d, href_p2_q, href_p2_d;
  logic             clken_p2_q, clken_p2_d, vld_p2_q, vld_p2_d;
  logic [7:0]       p11_q, p12_q, p13_q, p21_q, p22_q, p23_q;
  logic [7:0]       p31_q, p32_q, p33_q;
  logic [7:0]       p11_d, p12_d, p13_d, p21_d, p22_d, p23_d;
  logic [7:0]       p31_d, p32_d, p33_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;

  function automatic logic [COL_W-1:0] col_sat_inc(input logic [COL_W-1:0] v);
    return (v == COL_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [ROW_W-1:0] row_sat_inc(input logic [ROW_W-1:0] v);
    return (v == ROW_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    // Stage 1: register inputs
    y_p1_d     = per_img_y;
    vsync_p1_d = per_frame_vsync;
    href_p1_d  = per_frame_href;
    clken_p1_d = per_frame_clken;

    // Stage 2: window shift, sync delay, counters, validity
    vsync_p2_d = vsync_p1_q;
    href_p2_d  = href_p1_q;
    clken_p2_d = clken_p1_q;
    p11_d = p11_q; p12_d = p12_q; p13_d = p13_q;
    p21_d = p21_q; p22_d = p22_q; p23_d = p23_q;
    p31_d = p31_q; p32_d = p32_q; p33_d = p33_q;
    // Taps arrive one cycle after the pixel's clken, i.e. alongside y_p1.
    if (clken_p1_q) begin
      p11_d = p12_q; p12_d = p13_q; p13_d = tap_row2;
      p21_d = p22_q; p22_d = p23_q; p23_d = tap_row1;
      p31_d = p32_q; p32_d = p33_q; p33_d = y_p1_q;
    end

    col_cnt_d = col_cnt_q;
    if (!href_p1_q)
      col_cnt_d = '0;
    else if (clken_p1_q)
      col_cnt_d = col_sat_inc(col_cnt_q);

    // Frame-start clear takes priority over an end-of-line increment.
    row_cnt_d = row_cnt_q;
    if (vsync_p1_q && !vsync_p2_q)
      row_cnt_d = '0;
    else if (href_p2_q && !href_p1_q)
      row_cnt_d = row_sat_inc(row_cnt_q);

    vld_p2_d = clken_p1_q && href_p1_q &&
               (row_cnt_q >= ROW_W'(2)) && (col_cnt_q >= COL_W'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1_q     <= '0;
      vsync_p1_q <= 1'b0;
      href_p1_q  <= 1'b0;
      clken_p1_q <= 1'b0;
      vsync_p2_q <= 1'b0;
      href_p2_q  <= 1'b0;
      clken_p2_q <= 1'b0;
      vld_p2_q   <= 1'b0;
      p11_q <= '0; p12_q <= '0; p13_q <= '0;
      p21_q <= '0; p22_q <= '0; p23_q <= '0;
      p31_q <= '0; p32_q <= '0; p33_q <= '0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else begin
      y_p1_q     <= y_p1_d;
      vsync_p1_q <= vsync_p1_d;
      href_p1_q  <= href_p1_d;
      clken_p1_q <= clken_p1_d;
      vsync_p2_q <= vsync_p2_d;
      href_p2_q  <= href_p2_d;
      clken_p2_q <= clken_p2_d;
      vld_p2_q   <= vld_p2_d;
      p11_q <= p11_d; p12_q <= p12_d; p13_q <= p13_d;
      p21_q <= p21_d; p22_q <= p22_d; p23_q <= p23_d;
      p31_q <= p31_d; p32_q <= p32_d; p33_q <= p33_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  assign post_frame_vsync  = vsync_p2_q;
  assign post_frame_href   = href_p2_q;
  assign post_frame_clken  = clken_p2_q;
  assign post_window_valid = vld_p2_q;
  assign matrix_p11 = p11_q;
  assign matrix_p12 = p12_q;
  assign matrix_p13 = p13_q;
  assign matrix_p21 = p21_q;
  assign matrix_p22 = p22_q;
  assign matrix_p23 = p23_q;
  assign matrix_p31 = p31_q;
  assign matrix_p32 = p32_q;
  assign matrix_p33 = p33_q;

endmodule

// File: tb/tb_line_window_3x3_gen.sv
// Directed testbench for line_window_3x3_gen: 4x4 frames with pixel = 16*row+col
// and a line-buffer model that presents taps one cycle after each pixel.
module tb_line_window_3x3_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       per_frame_vsync, per_frame_href, per_frame_clken;
  logic [7:0] per_img_y, tap_row1, tap_row2;
  logic       post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;
  logic       post_window_valid;

  always #5 clk = ~clk;

  line_window_3x3_gen #(.MAX_COLS(16), .MAX_ROWS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .tap_row1(tap_row1), .tap_row2(tap_row2),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
    .post_window_valid(post_window_valid)
  );

  logic [75:0] all_outs;
  assign all_outs = {post_frame_vsync, post_frame_href, post_frame_clken,
                     post_window_valid, matrix_p11, matrix_p12, matrix_p13,
                     matrix_p21, matrix_p22, matrix_p23, matrix_p31,
                     matrix_p32, matrix_p33};

  int errs = 0;
  int checks = 0;
  int vcnt;
  int vmap [4][4];
  logic [7:0] p11m [4][4];
  logic [7:0] p13m [4][4];
  logic [7:0] p22m [4][4];
  logic [7:0] p31m [4][4];
  logic [7:0] p33m [4][4];

  logic       prev_vs, prev_hr, prev_ck;
  logic [7:0] prev_y;
  int         prev_r, prev_c;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prev();
    prev_vs = 1'b0; prev_hr = 1'b0; prev_ck = 1'b0;
    prev_y = 8'h00; prev_r = 15; prev_c = 15;
  endtask

  task automatic clear_maps();
    vcnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        vmap[r][c] = -1;
        p11m[r][c] = 8'hxx; p13m[r][c] = 8'hxx; p22m[r][c] = 8'hxx;
        p31m[r][c] = 8'hxx; p33m[r][c] = 8'hxx;
      end
  endtask

  // One clock: drive inputs at negedge, sample #1 after posedge. Outputs
  // then reflect the inputs driven in the previous call.
  task automatic cyc(input logic vs, input logic hr, input logic ck,
                     input int r, input int c);
    logic [7:0] y;
    y = 8'(16 * r + c);
    @(negedge clk);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_y       = y;
    if (prev_ck) begin
      tap_row1 = prev_y - 8'h10;
      tap_row2 = prev_y - 8'h20;
    end
    @(posedge clk);
    #1;
    chk("post_vsync", post_frame_vsync, prev_vs);
    chk("post_href", post_frame_href, prev_hr);
    chk("post_clken", post_frame_clken, prev_ck);
    if (post_window_valid === 1'b1) vcnt++;
    if (prev_ck && prev_hr && prev_r < 4 && prev_c < 4) begin
      vmap[prev_r][prev_c] = int'(post_window_valid);
      p11m[prev_r][prev_c] = matrix_p11;
      p13m[prev_r][prev_c] = matrix_p13;
      p22m[prev_r][prev_c] = matrix_p22;
      p31m[prev_r][prev_c] = matrix_p31;
      p33m[prev_r][prev_c] = matrix_p33;
    end
    prev_vs = vs; prev_hr = hr; prev_ck = ck; prev_y = y;
    prev_r = r; prev_c = c;
  endtask

  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 1'b0, 15, 15);
    cyc(1'b1, 1'b0, 1'b0, 15, 15);
    cyc(1'b0, 1'b0, 1'b0, 15, 15);
    cyc(1'b0, 1'b0, 1'b0, 15, 15);
  endtask

  task automatic blank();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 15, 15);
  endtask

  task automatic line(input int r);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 1'b1, r, c);
    blank();
  endtask

  task automatic chk_border(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_vld_r%0d_c%0d", tag, r, c), 128'(vmap[r][c]),
            128'((r >= 2 && c >= 2) ? 1 : 0));
  endtask

  initial begin
    rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_y = 8'h00; tap_row1 = 8'h00; tap_row2 = 8'h00;
    clear_prev();
    clear_maps();

    // Reset with random inputs: every output stays 0.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      per_frame_vsync = 1'($urandom); per_frame_href = 1'($urandom);
      per_frame_clken = 1'($urandom); per_img_y = 8'($urandom);
      tap_row1 = 8'($urandom); tap_row2 = 8'($urandom);
      @(posedge clk); #1;
      chk("reset_outs", all_outs, 76'd0);
    end
    @(negedge clk);
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_y = 8'h00; tap_row1 = 8'h00; tap_row2 = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_outs", all_outs, 76'd0);
    end

    // Frame 1: plain 4x4 frame.
    clear_maps();
    vs_pulse();
    for (int r = 0; r < 4; r++) line(r);
    chk("f1_p11_r2c2", p11m[2][2], 8'h00);
    chk("f1_p13_r2c2", p13m[2][2], 8'h02);
    chk("f1_p22_r2c2", p22m[2][2], 8'h11);
    chk("f1_p31_r2c2", p31m[2][2], 8'h20);
    chk("f1_p33_r2c2", p33m[2][2], 8'h22);
    chk("f1_p11_r3c3", p11m[3][3], 8'h11);
    chk("f1_p33_r3c3", p33m[3][3], 8'h33);
    chk("f1_vcnt", vcnt, 4);
    chk_border("f1");

    // Frame 2: 3 idle cycles between col 2 and col 3 of row 2, then restart.
    clear_maps();
    vs_pulse();
    line(0);
    line(1);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 1'b1, 2, c);
    cyc(1'b0, 1'b1, 1'b0, 15, 15);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cyc(1'b0, 1'b1, 1'b0, 15, 15);
      else       cyc(1'b0, 1'b1, 1'b1, 2, 3);
      chk("gap_p11", matrix_p11, 8'h00);
      chk("gap_p22", matrix_p22, 8'h11);
      chk("gap_p33", matrix_p33, 8'h22);
      chk("gap_vld", post_window_valid, 1'b0);
    end
    blank();
    chk("gap_vld_r2c2", vmap[2][2], 1);
    chk("gap_vld_r2c3", vmap[2][3], 1);
    chk("gap_p11_r2c3", p11m[2][3], 8'h01);
    chk("gap_p13_r2c3", p13m[2][3], 8'h03);
    chk("gap_p33_r2c3", p33m[2][3], 8'h23);
    chk("f2_vcnt", vcnt, 2);

    // Frame 3: vsync after row 2 restarts row counting.
    clear_maps();
    vs_pulse();
    for (int r = 0; r < 4; r++) line(r);
    chk("f3_vcnt", vcnt, 4);
    chk_border("f3");

    // Frame 4: asynchronous reset between edges at row 2 col 3.
    clear_maps();
    vs_pulse();
    line(0);
    line(1);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 1'b1, 2, c);
    chk("pre_rst_p33", matrix_p33, 8'h21);
    @(negedge clk);
    per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_y = 8'h23;
    tap_row1 = 8'h12; tap_row2 = 8'h02;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", all_outs, 76'd0);
    @(posedge clk); #1;
    chk("rst_hold_outs", all_outs, 76'd0);
    @(negedge clk);
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_y = 8'h00;
    rst_n = 1'b1;
    clear_prev();

    // Frame 5: full frame after reset release.
    clear_maps();
    vs_pulse();
    for (int r = 0; r < 4; r++) line(r);
    chk("f5_vcnt", vcnt, 4);
    chk("f5_p33_r3c3", p33m[3][3], 8'h33);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/line_window_3x3_gen.md
# line_window_3x3_gen

Consumer end of the two-tap line shift RAM. The line buffer writes the incoming pixel stream and returns the two previous lines as taps. This block reads those taps alongside the current-line pixel and assembles a registered 3x3 pixel window for the Sobel/NMS stages of the Canny pipeline. It also delays the frame sync signals to match the window, and flags which windows lie fully inside the image.

## Interface
- MAX_COLS, default 1024: maximum line length in pixels. This is the line buffer depth. It sets col_cnt width to clog2(MAX_COLS)+1.
- MAX_ROWS, default 1024: row counter saturation value. It sets row_cnt width to clog2(MAX_ROWS)+1.

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- per_frame_vsync  in  1  frame sync
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel valid strobe
- per_img_y  in  8  current-line pixel (also drives the line buffer shiftin)
- tap_row1  in  8  previous-line pixel, from line buffer taps0x
- tap_row2  in  8  line-before-previous pixel, from line buffer taps1x
- post_frame_vsync  out  1  per_frame_vsync delayed 2 cycles
- post_frame_href  out  1  per_frame_href delayed 2 cycles
- post_frame_clken  out  1  per_frame_clken delayed 2 cycles
- matrix_p11..p13  out  8 each  oldest row (from tap_row2); p11 is the leftmost/oldest column
- matrix_p21..p23  out  8 each  middle row (from tap_row1)
- matrix_p31..p33  out  8 each  newest row (current line); p33 is the newest pixel
- post_window_valid  out  1  window centred at (row-1, col-1) is fully inside the image

## Operation
- Stage 1 registers the input side: per_img_y becomes y_d1, and vsync, href and clken become their _d1 versions.
- Tap alignment contract: the line buffer presents the taps for a pixel one cycle after that pixel's clken. The taps are sampled on the same edge as y_d1 and clken_d1.
- Stage 2 shifts the window on each edge where clken_d1=1:
  - p11<=p12, p12<=p13, p13<=tap_row2
  - p21<=p22, p22<=p23, p23<=tap_row1
  - p31<=p32, p32<=p33, p33<=y_d1
- When clken_d1=0, all nine matrix registers hold.
- col_cnt behaviour:
  - Cleared when href_d1=0.
  - Increments by 1 on clken_d1 & href_d1.
  - Saturates at MAX_COLS.
- row_cnt behaviour:
  - Cleared on a rising edge of vsync_d1.
  - Increments by 1 on each falling edge of href_d1.
  - Saturates at MAX_ROWS.
- post_window_valid is registered as clken_d1 & href_d1 & (row_cnt>=2) & (col_cnt>=2). Both counters are taken at their pre-update values.
- Border windows, meaning the first two rows and first two columns of every line, are emitted with valid=0. Downstream treats them as zero gradient. There is no border replication.
- Window contents are not cleared between lines or frames. Stale left columns occur only when valid=0.
- Simultaneous events:
  - An href_d1 falling edge coinciding with a vsync_d1 rising edge clears row_cnt; the clear wins.
  - clken while href=0 shifts the matrix but never asserts valid and never advances col_cnt.

## Timing
- Latency is 2 cycles from per_frame_clken/per_img_y to the matrix and post_* outputs. All post_* signals are mutually aligned.
- Throughput is one window per cycle when clken is held high. Arbitrary clken gaps are allowed.
- Reset (async assert, sync-free deassert):
  - All matrix outputs, post_* signals, post_window_valid, counters and _d1 registers go to 0 immediately on assertion.
  - A reset mid-line discards the partial line. The first frame after reset needs a vsync rising edge before row counting is meaningful; row_cnt is 0 out of reset anyway.
- All outputs are registered. There is no combinational input-to-output path.

## Test plan
- Reset: drive random inputs with rst_n=0 → every output is 0. Release reset, then hold clken=0 for 10 cycles → outputs stay 0.
- Frame: 4x4 frame with pixel = 16*row+col and a line buffer model supplying the taps. For the clken of row 2 col 2, two cycles later: p11=0x00, p13=0x02, p22=0x11, p31=0x20, p33=0x22, post_window_valid=1. For row 3 col 3: p11=0x11, p33=0x33.
- Border suppression on the same frame: post_window_valid=0 for all 8 pixels of rows 0-1 and for cols 0-1 of rows 2-3. Exactly 4 valid pulses per frame.
- clken gaps: insert 3 idle cycles between col 2 and col 3 of row 2 → matrix holds 0x00..0x22 during the gap, valid=0, post_frame_clken tracks input with 2-cycle delay, next valid window has p33=0x23.
- Frame restart: raise vsync after row 2 → row_cnt clears, and the first two rows of the new frame produce no valid windows.
- Async reset mid-line: assert rst_n=0 at row 2 col 3 between clock edges → outputs are 0 before the next edge. After release and a new frame, the valid count is again 4.
